// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter: shares two register-file write ports among NREQ producers with
// round-robin priority, same-destination conflict avoidance and silent absorption of r0 writes.
module rf_wb_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned AW   = 6,
    parameter int unsigned DW   = 32
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               stall,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    output logic               we1,
    output logic [AW-1:0]      aw1,
    output logic [DW-1:0]      wd1,
    output logic               we2,
    output logic [AW-1:0]      aw2,
    output logic [DW-1:0]      wd2,
    output logic               busy
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]   ptr_q, ptr_d;
    logic            busy_q, busy_d;
    logic            we1_q, we1_d, we2_q, we2_d;
    logic [AW-1:0]   aw1_q, aw1_d, aw2_q, aw2_d;
    logic [DW-1:0]   wd1_q, wd1_d, wd2_q, wd2_d;

    logic [AW-1:0]   addr [NREQ];
    logic [DW-1:0]   data [NREQ];
    logic [NREQ-1:0] ready;
    logic            a_found, b_found;
    logic [PW-1:0]   a_idx, b_idx, idx, last_idx;

    function automatic logic [PW-1:0] wrap(input int unsigned v);
        int unsigned w;
        w = (v >= NREQ) ? v - NREQ : v;
        return w[PW-1:0];
    endfunction

    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            addr[i] = req_addr[i*AW +: AW];
            data[i] = req_data[i*DW +: DW];
        end
    end

    // Scan from ptr; r0 writes are accepted for free and never occupy a port slot.
    always_comb begin
        ready   = '0;
        a_found = 1'b0;
        b_found = 1'b0;
        a_idx   = '0;
        b_idx   = '0;
        idx     = '0;
        if (rstn && !stall) begin
            for (int unsigned k = 0; k < NREQ; k++) begin
                idx = wrap(32'(ptr_q) + k);
                if (req_valid[idx]) begin
                    if (addr[idx] == '0) begin
                        ready[idx] = 1'b1;
                    end else if (!a_found) begin
                        a_found    = 1'b1;
                        a_idx      = idx;
                        ready[idx] = 1'b1;
                    end else if (!b_found && addr[idx] != addr[a_idx]) begin
                        b_found    = 1'b1;
                        b_idx      = idx;
                        ready[idx] = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        last_idx = b_found ? b_idx : a_idx;
        ptr_d    = a_found ? wrap(32'(last_idx) + 32'd1) : ptr_q;
        busy_d   = stall ? busy_q : |(req_valid & ~ready);
        we1_d    = a_found;
        aw1_d    = a_found ? addr[a_idx] : '0;
        wd1_d    = a_found ? data[a_idx] : '0;
        we2_d    = b_found;
        aw2_d    = b_found ? addr[b_idx] : '0;
        wd2_d    = b_found ? data[b_idx] : '0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr_q  <= '0;
            busy_q <= 1'b0;
            we1_q  <= 1'b0;
            aw1_q  <= '0;
            wd1_q  <= '0;
            we2_q  <= 1'b0;
            aw2_q  <= '0;
            wd2_q  <= '0;
        end else begin
            ptr_q  <= ptr_d;
            busy_q <= busy_d;
            we1_q  <= we1_d;
            aw1_q  <= aw1_d;
            wd1_q  <= wd1_d;
            we2_q  <= we2_d;
            aw2_q  <= aw2_d;
            wd2_q  <= wd2_d;
        end
    end

    assign req_ready = ready;
    assign we1       = we1_q;
    assign aw1       = aw1_q;
    assign wd1       = wd1_q;
    assign we2       = we2_q;
    assign aw2       = aw2_q;
    assign wd2       = wd2_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed scenarios then random traffic, with a queue-based
// scoreboard fed by a rule-level reference model and drained by an independent monitor.
module tb_rf_wb_arbiter;

    localparam int unsigned NREQ = 4;
    localparam int unsigned AW   = 6;
    localparam int unsigned DW   = 32;

    typedef struct packed {
        logic          we1;
        logic [AW-1:0] aw1;
        logic [DW-1:0] wd1;
        logic          we2;
        logic [AW-1:0] aw2;
        logic [DW-1:0] wd2;
        logic          busy;
    } rec_t;

    logic               clk = 1'b0;
    logic               rstn, stall;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic               we1, we2, busy;
    logic [AW-1:0]      aw1, aw2;
    logic [DW-1:0]      wd1, wd2;

    int          checks   = 0;
    int          failures = 0;
    rec_t        exp_q[$];
    int unsigned ptr_m    = 0;
    logic        busy_m   = 1'b0;

    always #5 clk = ~clk;

    rf_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rstn(rstn), .stall(stall),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready),
        .we1(we1), .aw1(aw1), .wd1(wd1),
        .we2(we2), .aw2(aw2), .wd2(wd2),
        .busy(busy)
    );

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Drive one cycle of inputs, predict ready and the next registered outputs.
    task automatic step(input logic r, input logic s, input logic [NREQ-1:0] vv,
                        input logic [NREQ*AW-1:0] aa, input logic [NREQ*DW-1:0] dd,
                        output logic [NREQ-1:0] er);
        int unsigned cand[$];
        int unsigned ia, ib, i;
        logic        ha, hb;
        rec_t        e;
        @(negedge clk);
        rstn = r; stall = s; req_valid = vv; req_addr = aa; req_data = dd;
        #1;
        er = '0; ha = 1'b0; hb = 1'b0; ia = 0; ib = 0;
        cand.delete();
        if (r && !s) begin
            for (int unsigned k = 0; k < NREQ; k++) begin
                i = (ptr_m + k) % NREQ;
                if (vv[i]) begin
                    if (aa[i*AW +: AW] == '0) er[i] = 1'b1;
                    else cand.push_back(i);
                end
            end
            if (cand.size() > 0) begin
                ha = 1'b1; ia = cand[0]; er[ia] = 1'b1;
                for (int j = 1; j < cand.size(); j++) begin
                    if (!hb && aa[cand[j]*AW +: AW] != aa[ia*AW +: AW]) begin
                        hb = 1'b1; ib = cand[j]; er[ib] = 1'b1;
                    end
                end
            end
        end
        chk("req_ready", 128'(req_ready), 128'(er));
        e = '0;
        if (r) begin
            if (ha) begin e.we1 = 1'b1; e.aw1 = aa[ia*AW +: AW]; e.wd1 = dd[ia*DW +: DW]; end
            if (hb) begin e.we2 = 1'b1; e.aw2 = aa[ib*AW +: AW]; e.wd2 = dd[ib*DW +: DW]; end
            e.busy = s ? busy_m : |(vv & ~er);
            if (ha) ptr_m = ((hb ? ib : ia) + 1) % NREQ;
        end else begin
            ptr_m = 0;
        end
        busy_m = e.busy;
        exp_q.push_back(e);
    endtask

    task automatic chk_out(input string name, input logic e1, input logic [AW-1:0] a1,
                           input logic [DW-1:0] d1, input logic e2, input logic [AW-1:0] a2,
                           input logic [DW-1:0] d2, input logic eb);
        @(posedge clk);
        #2;
        chk(name, 128'({we1, aw1, wd1, we2, aw2, wd2, busy}),
            128'({e1, a1, d1, e2, a2, d2, eb}));
    endtask

    initial begin
        rec_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("wb_ports", 128'({we1, aw1, wd1, we2, aw2, wd2}),
                    128'({e.we1, e.aw1, e.wd1, e.we2, e.aw2, e.wd2}));
                chk("busy", 128'(busy), 128'(e.busy));
            end
        end
    end

    initial begin
        logic [NREQ-1:0]    er, rv;
        logic [NREQ*AW-1:0] a1234, ra;
        logic [NREQ*DW-1:0] d1234, rd;
        a1234 = {6'd4, 6'd3, 6'd2, 6'd1};
        d1234 = {32'h44, 32'h33, 32'h22, 32'h11};
        rstn = 1'b0; stall = 1'b0; req_valid = '0; req_addr = '0; req_data = '0;

        // Reset with everything valid: nothing accepted, ports idle.
        step(1'b0, 1'b0, 4'hF, a1234, d1234, er);
        chk("rst_ready", 128'(req_ready), 128'(4'b0000));
        step(1'b0, 1'b0, 4'hF, a1234, d1234, er);

        // Round robin with all four continuously valid.
        step(1'b1, 1'b0, 4'hF, a1234, d1234, er);
        chk("rr_ready0", 128'(req_ready), 128'(4'b0011));
        chk_out("rr_out0", 1'b1, 6'd1, 32'h11, 1'b1, 6'd2, 32'h22, 1'b1);
        step(1'b1, 1'b0, 4'hF, a1234, d1234, er);
        chk("rr_ready1", 128'(req_ready), 128'(4'b1100));
        step(1'b1, 1'b0, 4'hF, a1234, d1234, er);
        chk("rr_ready2", 128'(req_ready), 128'(4'b0011));
        step(1'b1, 1'b0, 4'hF, a1234, d1234, er);
        chk("rr_ready3", 128'(req_ready), 128'(4'b1100));

        // Two writers from ptr 0.
        step(1'b1, 1'b0, 4'b0101, {6'd0, 6'd9, 6'd0, 6'd5}, {32'h0, 32'h22, 32'h0, 32'h11}, er);
        chk("two_ready", 128'(req_ready), 128'(4'b0101));
        chk_out("two_out", 1'b1, 6'd5, 32'h11, 1'b1, 6'd9, 32'h22, 1'b0);

        // Same-destination conflict: one grant per cycle.
        step(1'b1, 1'b0, 4'b0011, {6'd0, 6'd0, 6'd7, 6'd7}, {32'h0, 32'h0, 32'hB, 32'hA}, er);
        chk("conf_ready0", 128'(req_ready), 128'(4'b0001));
        chk_out("conf_out0", 1'b1, 6'd7, 32'hA, 1'b0, 6'd0, 32'h0, 1'b1);
        step(1'b1, 1'b0, 4'b0010, {6'd0, 6'd0, 6'd7, 6'd7}, {32'h0, 32'h0, 32'hB, 32'hA}, er);
        chk("conf_ready1", 128'(req_ready), 128'(4'b0010));
        chk_out("conf_out1", 1'b1, 6'd7, 32'hB, 1'b0, 6'd0, 32'h0, 1'b0);

        // Zero-address writes are absorbed.
        step(1'b1, 1'b0, 4'b0010, {6'd0, 6'd0, 6'd0, 6'd0}, {32'h0, 32'h0, 32'h55, 32'h0}, er);
        chk("zero_ready", 128'(req_ready), 128'(4'b0010));
        chk_out("zero_out", 1'b0, 6'd0, 32'h0, 1'b0, 6'd0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 4'b1010, {6'd4, 6'd0, 6'd0, 6'd0}, {32'h44, 32'h0, 32'h55, 32'h0}, er);
        chk("zero_mix_ready", 128'(req_ready), 128'(4'b1010));
        chk_out("zero_mix_out", 1'b1, 6'd4, 32'h44, 1'b0, 6'd0, 32'h0, 1'b0);

        // Stall for three cycles, then resume from the held pointer.
        step(1'b1, 1'b1, 4'hF, a1234, d1234, er);
        chk("stall_ready", 128'(req_ready), 128'(4'b0000));
        chk("stall_inflight", 128'({we1, aw1}), 128'({1'b1, 6'd4}));
        step(1'b1, 1'b1, 4'hF, a1234, d1234, er);
        chk("stall_we", 128'({we1, we2}), 128'(2'b00));
        step(1'b1, 1'b1, 4'hF, a1234, d1234, er);
        step(1'b1, 1'b0, 4'hF, a1234, d1234, er);
        chk("resume_ready", 128'(req_ready), 128'(4'b0011));

        // Random traffic; small address range forces conflicts and r0 writes.
        rv = '0; er = '0; ra = '0; rd = '0;
        for (int c = 0; c < 400; c++) begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (!rv[i] || er[i]) begin
                    rv[i]            = ($urandom_range(0, 2) != 0);
                    ra[i*AW +: AW]   = AW'($urandom_range(0, 7));
                    rd[i*DW +: DW]   = $urandom;
                end
            end
            step((c != 200) && (c != 201), ($urandom_range(0, 7) == 0), rv, ra, rd, er);
        end

        @(posedge clk);
        #3;
        chk("queue_drained", 128'(exp_q.size()), 128'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
